inst_fetch_unit: RTL

Front-end stage that feeds the decode/execute core. It fetches instruction bytes from a byte-wide instruction memory, buffers them in a small prefetch FIFO, and assembles complete 1- or 2-byte instructions. Each instruction is presented with its PC over a valid/ready handshake. Jump redirects from the core flush the buffer and restart fetch at the target address.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_byte_fifo.sv | 56 +++++
 rtl/inst_fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared defaults and opcode-length decoding for the instruction fetch unit.
package ifu_pkg;

   localparam int AW_DEF = 13;
   localparam int DW_DEF = 8;

   // Opcodes 110x_xxxx form the long class alongside every opcode with bit 7 clear.
   localparam logic [DW_DEF-1:0] OPC_LONG_MASK = 8'hE0;
   localparam logic [DW_DEF-1:0] OPC_LONG_VAL  = 8'hC0;

   function automatic logic is_two_byte(input logic [DW_DEF-1:0] op);
      return !op[DW_DEF-1] || ((op & OPC_LONG_MASK) == OPC_LONG_VAL);
   endfunction

endpackage

// File: rtl/ifu_byte_fifo.sv
// Byte prefetch buffer: circular store with a two-entry peek, push of one, pop of one or two.
// Zero-latency peek; flush overrides push and pop in the same cycle.
module ifu_byte_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [DW-1:0]              push_dat,
   input  logic                       pop,
   input  logic                       pop_two,
   output logic [DW-1:0]              head0,
   output logic [DW-1:0]              head1,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] store [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr_p1;
   logic [CW-1:0] pop_n;
   logic [CW-1:0] push_n;

   assign rd_ptr_p1 = rd_ptr + PW'(1);
   assign head0     = store[rd_ptr];
   assign head1     = store[rd_ptr_p1];
   assign pop_n     = !pop ? '0 : (pop_two ? CW'(2) : CW'(1));
   assign push_n    = CW'(push);

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         store[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so pointer arithmetic wraps on its own.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         rd_ptr <= rd_ptr + pop_n[PW-1:0];
         count  <= count + push_n - pop_n;
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetches bytes one request at a time, buffers them and presents whole 1/2-byte instructions
// with PC over valid/ready; redirect flushes and restarts. IFU_PERF_EN adds saturating perf counters.
module inst_fetch_unit
   import ifu_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rvalid,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_addr,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [DW-1:0] inst_op,
   output logic [DW-1:0] inst_ext,
   output logic          inst_two_byte,
   output logic [AW-1:0] inst_pc,
   output logic [AW-1:0] inst_next_pc
`ifdef IFU_PERF_EN
  ,output logic [15:0]   perf_inst_cnt,
   output logic [15:0]   perf_flush_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0] issue_pc;
   logic          outstanding;
   logic          discard;
   logic [DW-1:0] head0;
   logic [DW-1:0] head1;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_nonempty;
   logic          head_two;
   logic          head_full;
   logic          fifo_push;
   logic          fifo_pop;
   logic          issue_ok;

   assign fifo_nonempty = (fifo_cnt != '0);
   assign head_two      = fifo_nonempty && is_two_byte(head0);
   assign head_full     = (fifo_cnt >= CW'(2));

   assign inst_valid    = head_two ? head_full : fifo_nonempty;
   assign inst_two_byte = head_two;
   assign inst_op       = fifo_nonempty ? head0 : '0;
   assign inst_ext      = (head_two && head_full) ? head1 : '0;
   assign inst_next_pc  = !fifo_nonempty ? inst_pc
                                         : inst_pc + (head_two ? AW'(2) : AW'(1));

   // Only one request ever flies, so an idle bus plus a free slot reserves room for its byte.
   assign issue_ok  = !outstanding && !redirect && (fifo_cnt < CW'(DEPTH));
   assign fifo_push = mem_rvalid && outstanding && !discard && !redirect;
   assign fifo_pop  = inst_valid && inst_ready && !redirect;

   ifu_byte_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .push     (fifo_push),
      .push_dat (mem_rdata),
      .pop      (fifo_pop),
      .pop_two  (head_two),
      .head0    (head0),
      .head1    (head1),
      .count    (fifo_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_pc    <= '0;
         inst_pc     <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         outstanding <= 1'b0;
         discard     <= 1'b0;
      end else if (redirect) begin
         // A response landing this very cycle is simply dropped; a later one gets discarded.
         issue_pc    <= redirect_addr;
         inst_pc     <= redirect_addr;
         mem_req     <= 1'b0;
         outstanding <= outstanding && !mem_rvalid;
         discard     <= outstanding && !mem_rvalid;
      end else begin
         mem_req <= issue_ok;
         if (issue_ok) begin
            mem_addr    <= issue_pc;
            issue_pc    <= issue_pc + AW'(1);
            outstanding <= 1'b1;
         end else if (mem_rvalid && outstanding) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
         end
         if (fifo_pop) begin
            inst_pc <= inst_next_pc;
         end
      end
   end

`ifdef IFU_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_inst_cnt  <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (fifo_pop && perf_inst_cnt != 16'hFFFF) begin
            perf_inst_cnt <= perf_inst_cnt + 16'd1;
         end
         if (redirect && perf_flush_cnt != 16'hFFFF) begin
            perf_flush_cnt <= perf_flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
